// File: rtl/neopixel_strand_engine.sv
// neopixel_strand_engine
//   WS2812-style strand driver. The host writes colour bytes into a frame
//   buffer of NUM_PIXELS 24-bit GRB words, then requests a transmit. The
//   engine serialises pixel 0 first, each pixel as G,R,B MSB first. Every
//   bit is a high phase followed by a low phase. A latch gap follows the
//   last bit, and then frame_done pulses for one cycle.
//
//   Optional feature macro: NEO_BRIGHTNESS_EN
//     When defined, the design adds a brightness[7:0] input. It is captured
//     when a send is accepted, and every transmitted byte is scaled by it.
//     The buffer itself is never modified.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-high
//   color_level    in   [7:0] byte to store
//   color_index    in   [1:0] 00=R, 01=B, 10=G, 11=no write
//   pixel_index    in   [PIX_W-1:0] target pixel, >= NUM_PIXELS ignored
//   load_color     in   write request (taken when ready_to_load)
//   send_it        in   transmit request (taken when ready_to_send)
//   brightness     in   [7:0] scale factor (NEO_BRIGHTNESS_EN only)
//   neo_data       out  serial strand data
//   ready_to_load  out  buffer writable (IDLE or LATCH)
//   ready_to_send  out  transmit can start (IDLE)
//   frame_done     out  one-cycle pulse when LATCH returns to IDLE
module neopixel_strand_engine #(
  parameter int NUM_PIXELS = 8,
  parameter int T1H        = 35,
  parameter int T1L        = 30,
  parameter int T0H        = 18,
  parameter int T0L        = 40,
  parameter int TRESET     = 2500,
  localparam int PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       color_level,
  input  logic [1:0]       color_index,
  input  logic [PIX_W-1:0] pixel_index,
  input  logic             load_color,
  input  logic             send_it,
`ifdef NEO_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             neo_data,
  output logic             ready_to_load,
  output logic             ready_to_send,
  output logic             frame_done
);

  localparam int MAX_HI  = (T1H > T0H) ? T1H : T0H;
  localparam int MAX_LO  = (T1L > T0L) ? T1L : T0L;
  localparam int MAX_BIT = (MAX_HI > MAX_LO) ? MAX_HI : MAX_LO;
  localparam int MAX_T   = (MAX_BIT > TRESET) ? MAX_BIT : TRESET;
  localparam int CNT_W   = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] T1H_LAST    = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_LAST    = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] T0H_LAST    = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_LAST    = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] TRESET_LAST = CNT_W'(TRESET - 1);
  localparam logic [PIX_W-1:0] LAST_PIX    = PIX_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W:0]   PIX_LIMIT   = (PIX_W + 1)'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [23:0]      shift_reg;
  logic [23:0]      frame_buf [NUM_PIXELS];

  logic             write_en;
  logic             send_accept;
  logic             last_pix;
  logic [PIX_W-1:0] next_pix;
  logic [CNT_W-1:0] high_last;
  logic [CNT_W-1:0] low_last;
  logic [23:0]      first_word;
  logic [23:0]      next_word;

`ifdef NEO_BRIGHTNESS_EN
  logic [7:0] bright_reg;

  // (level * (brightness + 1)) >> 8, so 255 passes the byte through unchanged.
  function automatic logic [7:0] scale_byte(input logic [7:0] level, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, level} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
    return {scale_byte(w[23:16], b), scale_byte(w[15:8], b), scale_byte(w[7:0], b)};
  endfunction
`endif

  assign ready_to_load = (state == IDLE) || (state == LATCH);
  assign ready_to_send = (state == IDLE);

  // A simultaneous load wins over send, even when the load itself is a no-op.
  assign send_accept = (state == IDLE) && send_it && !load_color;
  assign write_en    = load_color && ready_to_load && (color_index != 2'b11)
                       && ({1'b0, pixel_index} < PIX_LIMIT);

  assign last_pix  = (pix_cnt == LAST_PIX);
  assign next_pix  = last_pix ? '0 : pix_cnt + 1'b1;
  assign high_last = shift_reg[23] ? T1H_LAST : T0H_LAST;
  assign low_last  = shift_reg[23] ? T1L_LAST : T0L_LAST;

  // Pixel 0 is scaled by the live brightness because the register captures
  // it on the same edge. Later pixels use the value held for this frame.
`ifdef NEO_BRIGHTNESS_EN
  assign first_word = scale_word(frame_buf[0], brightness);
  assign next_word  = scale_word(frame_buf[next_pix], bright_reg);
`else
  assign first_word = frame_buf[0];
  assign next_word  = frame_buf[next_pix];
`endif

  // Frame buffer: one byte per accepted write, the other bytes hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) frame_buf[i] <= '0;
    end else if (write_en) begin
      case (color_index)
        2'b00:   frame_buf[pixel_index][15:8]  <= color_level;
        2'b01:   frame_buf[pixel_index][7:0]   <= color_level;
        2'b10:   frame_buf[pixel_index][23:16] <= color_level;
        default: ;
      endcase
    end
  end

  // Transmit FSM. neo_data is registered and changes on the same edge as
  // the state, so each phase lasts exactly its count of cycles. The next
  // pixel is fetched directly into HIGH, so no gap cycle appears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      shift_reg  <= '0;
      neo_data   <= 1'b0;
      frame_done <= 1'b0;
`ifdef NEO_BRIGHTNESS_EN
      bright_reg <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (send_accept) begin
            state     <= HIGH;
            shift_reg <= first_word;
            bit_cnt   <= 5'd23;
            pix_cnt   <= '0;
            cnt       <= '0;
            neo_data  <= 1'b1;
`ifdef NEO_BRIGHTNESS_EN
            bright_reg <= brightness;
`endif
          end
        end
        HIGH: begin
          if (cnt == high_last) begin
            state    <= LOW;
            cnt      <= '0;
            neo_data <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt == low_last) begin
            cnt <= '0;
            if (bit_cnt != 5'd0) begin
              bit_cnt   <= bit_cnt - 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
              state     <= HIGH;
              neo_data  <= 1'b1;
            end else if (!last_pix) begin
              pix_cnt   <= next_pix;
              shift_reg <= next_word;
              bit_cnt   <= 5'd23;
              state     <= HIGH;
              neo_data  <= 1'b1;
            end else begin
              state <= LATCH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          if (cnt == TRESET_LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
